// File: rtl/cv32e40x_xif_offload.sv
// Offloads one custom instruction at a time over XIF issue/commit/result; best case 4 cycles req->writeback.
// req_ready_o only in IDLE; issue fields held until issue_ready_i; results are always accepted.
module cv32e40x_xif_offload #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_instr_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs1_i,
  input  logic [X_RFR_WIDTH-1:0] req_rs2_i,
  input  logic                   kill_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [31:0]            issue_instr_o,
  output logic [X_ID_WIDTH-1:0]  issue_id_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs0_o,
  output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
  output logic [1:0]             issue_rs_valid_o,
  input  logic                   issue_accept_i,
  input  logic                   issue_writeback_i,
  output logic                   commit_valid_o,
  output logic [X_ID_WIDTH-1:0]  commit_id_o,
  output logic                   commit_kill_o,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [X_ID_WIDTH-1:0]  result_id_i,
  input  logic [4:0]             result_rd_i,
  input  logic [X_RFR_WIDTH-1:0] result_data_i,
  input  logic                   result_we_i,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFR_WIDTH-1:0] wb_data_o,
  output logic                   illegal_o,
  output logic                   done_o,
  output logic                   stray_result_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT, WAIT_RESULT} state_e;

  localparam logic [X_ID_WIDTH-1:0] ID_ONE = {{(X_ID_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [X_ID_WIDTH-1:0]  id_cnt_q, id_cnt_d;
  logic [X_ID_WIDTH-1:0]  id_q, id_d;
  logic [31:0]            instr_q, instr_d;
  logic [X_RFR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic                   kill_pend_q, kill_pend_d;
  logic                   wb_exp_q, wb_exp_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [X_RFR_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                   illegal_q, illegal_d;
  logic                   done_q, done_d;
  logic                   stray_q, stray_d;
  logic                   result_match;
  logic                   unused_wb_exp;

  // The coprocessor's writeback promise is kept for visibility; writeback itself follows result_we_i.
  assign unused_wb_exp = wb_exp_q;

  assign result_match = (state_q == WAIT_RESULT) && result_valid_i && (result_id_i == id_q);

  always_comb begin
    state_d     = state_q;
    id_cnt_d    = id_cnt_q;
    id_d        = id_q;
    instr_d     = instr_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    kill_pend_d = kill_pend_q;
    wb_exp_d    = wb_exp_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    illegal_d   = 1'b0;
    done_d      = 1'b0;
    stray_d     = result_valid_i && !result_match;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          instr_d     = req_instr_i;
          rs1_d       = req_rs1_i;
          rs2_d       = req_rs2_i;
          kill_pend_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (kill_i) kill_pend_d = 1'b1;
        if (issue_ready_i) begin
          id_d     = id_cnt_q;
          id_cnt_d = id_cnt_q + ID_ONE;
          if (issue_accept_i) begin
            wb_exp_d = issue_writeback_i;
            state_d  = COMMIT;
          end else begin
            illegal_d = 1'b1;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      COMMIT: begin
        if (kill_pend_q || kill_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (result_match) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (result_we_i && (result_rd_i != 5'd0)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = result_rd_i;
            wb_data_d  = result_data_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      id_cnt_q    <= '0;
      id_q        <= '0;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      kill_pend_q <= 1'b0;
      wb_exp_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      illegal_q   <= 1'b0;
      done_q      <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_cnt_q    <= id_cnt_d;
      id_q        <= id_d;
      instr_q     <= instr_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      kill_pend_q <= kill_pend_d;
      wb_exp_q    <= wb_exp_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      illegal_q   <= illegal_d;
      done_q      <= done_d;
      stray_q     <= stray_d;
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign issue_valid_o    = (state_q == ISSUE);
  assign issue_instr_o    = instr_q;
  assign issue_id_o       = id_cnt_q;
  assign issue_rs0_o      = rs1_q;
  assign issue_rs1_o      = rs2_q;
  assign issue_rs_valid_o = {2{state_q == ISSUE}};
  assign commit_valid_o   = (state_q == COMMIT);
  assign commit_id_o      = id_q;
  // A kill arriving in the commit cycle itself still turns the commit into a kill.
  assign commit_kill_o    = (state_q == COMMIT) && (kill_pend_q || kill_i);
  assign result_ready_o   = 1'b1;
  assign wb_valid_o       = wb_valid_q;
  assign wb_rd_o          = wb_rd_q;
  assign wb_data_o        = wb_data_q;
  assign illegal_o        = illegal_q;
  assign done_o           = done_q;
  assign stray_result_o   = stray_q;

endmodule
